wt_inval_queue: RTL and testbench
=================================

WT_INVAL_QUEUE -- requirements
Module: wt_inval_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of queue entries, power of two, 2..16.
REQ-002 SHALL have parameter ADDR_W, default 64; invalidation address width.
REQ-003 SHALL have parameter OFFSET_W, default 4; cache-line offset bits (DCACHE_OFFSET_WIDTH).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 snoop_valid_i  in  1  upstream invalidation request valid.
REQ-007 snoop_addr_i  in  ADDR_W  upstream physical address, any byte alignment.
REQ-008 snoop_ready_o  out  1  request accepted this cycle when high with snoop_valid_i.
REQ-009 inval_valid_o  out  1  drives cache subsystem inval_valid_i.
REQ-010 inval_addr_o  out  ADDR_W  drives cache subsystem inval_addr_i; line-aligned.
REQ-011 inval_ready_i  in  1  from cache subsystem inval_ready_o.
REQ-012 occupancy_o  out  $clog2(DEPTH)+1  number of valid entries.
REQ-013 merge_cnt_o  out  16  saturating count of requests dropped as duplicates.

Function
REQ-014 Aligned address SHALL be snoop_addr_i with bits [OFFSET_W-1:0] forced to 0; only aligned addresses are stored, compared and emitted.
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries with read pointer, write pointer and count; pointers wrap DEPTH-1 -> 0.
REQ-016 inval_valid_o SHALL equal (count != 0); inval_addr_o SHALL equal the head entry, held stable while inval_valid_o && !inval_ready_i.
REQ-017 Pop SHALL occur when inval_valid_o && inval_ready_i; read pointer advances 1.
REQ-018 Duplicate hit SHALL be asserted when the aligned address equals any valid entry, excluding the head entry in a cycle where that head is popped.
REQ-019 snoop_ready_o SHALL be 1 when count < DEPTH or duplicate hit; SHALL be 0 when count == DEPTH and no hit (no same-cycle pass-through of a pop; no combinational path inval_ready_i -> snoop_ready_o except via REQ-018 head exclusion).
REQ-020 On snoop_valid_i && snoop_ready_o with duplicate hit: no push; merge_cnt_o increments by 1, saturating at 16'hFFFF.
REQ-021 On snoop_valid_i && snoop_ready_o without hit: push aligned address at write pointer; write pointer advances 1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push only +1; pop only -1; count never exceeds DEPTH nor goes below 0.
REQ-023 Request arriving while queue empty SHALL appear on inval_valid_o the next cycle (latency 1, no bypass).
REQ-024 Ordering: non-merged requests SHALL be emitted in acceptance order.
REQ-025 occupancy_o SHALL equal count registered value.

Reset
REQ-026 While rst_ni == 0, asynchronously: pointers, count, entry valid bits and merge_cnt_o SHALL be 0; inval_valid_o = 0, occupancy_o = 0; snoop_ready_o = 1 after reset.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries; no entry SHALL be emitted after reset release without a new push.
REQ-028 Entry data registers need no reset; inval_addr_o is don't-care while inval_valid_o == 0.

Verification
REQ-029 Empty queue, push 0x8000_1234 with inval_ready_i=1 -> next cycle inval_valid_o=1, inval_addr_o=0x8000_1230; popped, occupancy returns 0.
REQ-030 inval_ready_i=0, push 0x100,0x200,0x300,0x400 (DEPTH=4) -> occupancy_o=4, snoop_ready_o=0 for new 0x500; 0x408 accepted and merge_cnt_o=1, occupancy stays 4.
REQ-031 Full queue, head 0x100, inval_ready_i=1 and snoop 0x104 same cycle -> not a hit (head popping), snoop_ready_o=0; next cycle 0x104 accepted as new entry 0x100.
REQ-032 Continuous push/pop 20 distinct lines at one per cycle -> emitted in order, pointers wrap, occupancy stays 1, merge_cnt_o=0.
REQ-033 Queue holds 3 entries, rst_ni pulsed low mid-cycle -> inval_valid_o=0 immediately, occupancy_o=0, merge_cnt_o=0; no stale emission after release.
REQ-034 Force merge_cnt_o to 0xFFFF via 65535+ duplicate hits -> remains 0xFFFF on further hits.

Source files
------------

// File: rtl/wt_inval_queue.sv
// Invalidation request queue between a snoop source and the write-through cache.
// Buffers line-aligned addresses in FIFO order and drops requests that duplicate a queued line.
module wt_inval_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       snoop_valid_i,
  input  logic [ADDR_W-1:0]          snoop_addr_i,
  output logic                       snoop_ready_o,
  output logic                       inval_valid_o,
  output logic [ADDR_W-1:0]          inval_addr_o,
  input  logic                       inval_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [15:0]                merge_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [15:0]       merge_cnt_q;

  logic [ADDR_W-1:0] aligned_addr;
  logic              pop;
  logic              hit;
  logic              full;
  logic              accept;
  logic              push;
  logic              merge;

  assign aligned_addr = snoop_addr_i & ~OFFSET_MASK;
  assign pop          = inval_valid_o && inval_ready_i;

  // The head leaving this cycle cannot absorb a duplicate, so it is skipped when popping.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i] == aligned_addr) &&
          !(pop && (PTR_W'(i) == rd_ptr_q))) begin
        hit = 1'b1;
      end
    end
  end

  assign full          = (count_q == CNT_W'(DEPTH));
  assign snoop_ready_o = !full || hit;
  assign accept        = snoop_valid_i && snoop_ready_o;
  assign push          = accept && !hit;
  assign merge         = accept && hit;

  assign inval_valid_o = (count_q != '0);
  assign inval_addr_o  = entry_q[rd_ptr_q];
  assign occupancy_o   = count_q;
  assign merge_cnt_o   = merge_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      merge_cnt_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      // Push and pop never target the same slot: that needs an empty or a full queue.
      valid_q <= (valid_q & ~(DEPTH'(pop) << rd_ptr_q)) | (DEPTH'(push) << wr_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (merge && (merge_cnt_q != 16'hFFFF)) begin
        merge_cnt_q <= merge_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_q[wr_ptr_q] <= aligned_addr;
    end
  end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Self-checking bench for wt_inval_queue: a reference queue model predicts every
// emitted address, ready, occupancy and merge count, cycle by cycle.
module tb_wt_inval_queue;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 64;
  localparam int OFFSET_W = 4;

  logic              clk_i;
  logic              rst_ni;
  logic              snoop_valid_i;
  logic [ADDR_W-1:0] snoop_addr_i;
  logic              snoop_ready_o;
  logic              inval_valid_o;
  logic [ADDR_W-1:0] inval_addr_o;
  logic              inval_ready_i;
  logic [2:0]        occupancy_o;
  logic [15:0]       merge_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [15:0]       exp_merge = 16'd0;

  wt_inval_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .snoop_valid_i(snoop_valid_i),
    .snoop_addr_i (snoop_addr_i),
    .snoop_ready_o(snoop_ready_o),
    .inval_valid_o(inval_valid_o),
    .inval_addr_o (inval_addr_o),
    .inval_ready_i(inval_ready_i),
    .occupancy_o  (occupancy_o),
    .merge_cnt_o  (merge_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model, then advance the model.
  task automatic apply_stimulus(input logic v, input logic [63:0] addr, input logic rdy, input string tag);
    logic [63:0] aligned;
    bit          pop;
    bit          hit;
    bit          ready;
    @(negedge clk_i);
    snoop_valid_i = v;
    snoop_addr_i  = addr;
    inval_ready_i = rdy;
    #1;
    aligned = addr & ~64'hF;
    pop     = (exp_q.size() != 0) && rdy;
    hit     = 1'b0;
    for (int i = (pop ? 1 : 0); i < exp_q.size(); i++) begin
      if (exp_q[i] == aligned) hit = 1'b1;
    end
    ready = (exp_q.size() < DEPTH) || hit;
    check_output({tag, ".valid"}, 64'(inval_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_output({tag, ".addr"}, inval_addr_o, exp_q[0]);
    check_output({tag, ".ready"}, 64'(snoop_ready_o), 64'(ready));
    check_output({tag, ".occ"}, 64'(occupancy_o), 64'(exp_q.size()));
    check_output({tag, ".merge"}, 64'(merge_cnt_o), 64'(exp_merge));
    if (pop) void'(exp_q.pop_front());
    if (v && ready) begin
      if (hit) begin
        if (exp_merge != 16'hFFFF) exp_merge++;
      end else begin
        exp_q.push_back(aligned);
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      apply_stimulus(1'b0, 64'h0, 1'b1, tag);
    end
    check_output({tag, ".empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    snoop_valid_i = 1'b0;
    snoop_addr_i  = '0;
    inval_ready_i = 1'b0;
    #12;
    check_output("reset.valid", 64'(inval_valid_o), 64'd0);
    check_output("reset.occ", 64'(occupancy_o), 64'd0);
    check_output("reset.merge", 64'(merge_cnt_o), 64'd0);
    check_output("reset.ready", 64'(snoop_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single request: latency one, aligned on output, then popped.
    apply_stimulus(1'b1, 64'h8000_1234, 1'b1, "single");
    apply_stimulus(1'b0, 64'h0, 1'b1, "single_out");
    apply_stimulus(1'b0, 64'h0, 1'b1, "single_empty");

    // Fill, reject when full, merge a duplicate while full.
    apply_stimulus(1'b1, 64'h100, 1'b0, "fill0");
    apply_stimulus(1'b1, 64'h200, 1'b0, "fill1");
    apply_stimulus(1'b1, 64'h300, 1'b0, "fill2");
    apply_stimulus(1'b1, 64'h400, 1'b0, "fill3");
    apply_stimulus(1'b1, 64'h500, 1'b0, "full_reject");
    apply_stimulus(1'b1, 64'h408, 1'b0, "full_merge");
    apply_stimulus(1'b0, 64'h0, 1'b0, "after_merge");
    check_output("merge_one", 64'(merge_cnt_o), 64'd1);

    // Popping head is not a duplicate target; the same line re-enters as a new entry.
    apply_stimulus(1'b1, 64'h104, 1'b1, "head_pop_snoop");
    apply_stimulus(1'b1, 64'h104, 1'b0, "head_reenter");
    drain("drain1");

    // Streaming distinct lines: one in, one out per cycle, pointers wrap several times.
    apply_stimulus(1'b1, 64'h1_0000, 1'b1, "stream_first");
    for (int i = 1; i < 20; i++) begin
      apply_stimulus(1'b1, 64'h1_0000 + 64'(i) * 64'h40 + 64'(i % 16), 1'b1, "stream");
      check_output("stream.occ1", 64'(occupancy_o), 64'd1);
    end
    drain("drain2");

    // Asynchronous reset mid-cycle with three pending entries.
    apply_stimulus(1'b1, 64'hA00, 1'b0, "pre_rst0");
    apply_stimulus(1'b1, 64'hB00, 1'b0, "pre_rst1");
    apply_stimulus(1'b1, 64'hC00, 1'b0, "pre_rst2");
    apply_stimulus(1'b0, 64'h0, 1'b0, "pre_rst3");
    @(negedge clk_i);
    snoop_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("midrst.valid", 64'(inval_valid_o), 64'd0);
    check_output("midrst.occ", 64'(occupancy_o), 64'd0);
    check_output("midrst.merge", 64'(merge_cnt_o), 64'd0);
    exp_q.delete();
    exp_merge = 16'd0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 64'h0, 1'b1, "post_rst");

    // Saturate the merge counter against one held entry.
    apply_stimulus(1'b1, 64'hD00, 1'b0, "sat_seed");
    for (int i = 0; i < 65540; i++) begin
      apply_stimulus(1'b1, 64'hD00 + 64'(i % 16), 1'b0, "sat");
    end
    apply_stimulus(1'b0, 64'h0, 1'b0, "sat_end");
    check_output("sat.ffff", 64'(merge_cnt_o), 64'hFFFF);
    check_output("sat.occ", 64'(occupancy_o), 64'd1);
    drain("drain3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
